// File: rtl/sd_spi_pkg.sv
// rtl/sd_spi_pkg.sv - shared types, constants and CRC7 step for the SD SPI target
package sd_spi_pkg;

  // Command framer: waiting for a start byte, collecting the argument, awaiting the CRC byte.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARG  = 2'd1,
    CRC  = 2'd2
  } framer_state_e;

  localparam logic [1:0] CMD_START_BITS = 2'b01;
  localparam logic [6:0] CRC7_POLY      = 7'h09;

  // One serial step of the SD CRC7 (x^7 + x^3 + 1), MSB-first data.
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic data_bit);
    logic fb;
    fb = crc[6] ^ data_bit;
    crc7_next = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_spi_target_if.sv
// rtl/sd_spi_target_if.sv - SPI line and host-side stream bundle for sd_spi_target
// slave modport: the card side (sd_spi_target). master modport: whoever drives SPI and TX.
//   SPI:  SCLK, MOSI, nCS (to card), MISO (from card)
//   RX:   RX_DATA/RX_VALID byte stream, CMD_VALID/CMD_INDEX/CMD_ARG/CMD_CRC_OK frames
//   TX:   TX_DATA/TX_VALID offered by host, TX_READY pulses on consumption
interface sd_spi_target_if;
  logic        SCLK;
  logic        MOSI;
  logic        nCS;
  logic        MISO;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        CMD_VALID;
  logic [5:0]  CMD_INDEX;
  logic [31:0] CMD_ARG;
  logic        CMD_CRC_OK;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;

  modport slave (
    input  SCLK, MOSI, nCS, TX_DATA, TX_VALID,
    output MISO, RX_DATA, RX_VALID, CMD_VALID, CMD_INDEX, CMD_ARG, CMD_CRC_OK, TX_READY
  );

  modport master (
    output SCLK, MOSI, nCS, TX_DATA, TX_VALID,
    input  MISO, RX_DATA, RX_VALID, CMD_VALID, CMD_INDEX, CMD_ARG, CMD_CRC_OK, TX_READY
  );
endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-FF synchroniser with single-cycle rise/fall pulses
// Ports: clk_i, rst_i (sync, active-high), async_i (raw line),
//        sync_o (synchronised level), rise_o / fall_o (one-cycle edge pulses).
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic meta_q, sync_q, prev_q;

  // Reset to the line's idle level so no spurious edge is seen coming out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/sd_spi_target.sv
// rtl/sd_spi_target.sv - SPI mode-0 SD card target: byte deserialiser, command framer, response serialiser
// Ports: CLKX4 (oversampling clock, >= 4x SCLK), RESET (sync, active-high),
//        bus (sd_spi_target_if.slave): SPI lines, received bytes/commands, response stream.
module sd_spi_target
  import sd_spi_pkg::*;
#(
  parameter int         NCR_BYTES = 1,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic            CLKX4,
  input  logic            RESET,
  sd_spi_target_if.slave  bus
);
  localparam logic [3:0] NCR_LOAD = 4'(NCR_BYTES);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic ncs_sync, ncs_rise_unused, ncs_fall;
  logic mosi_meta_q, mosi_sync_q;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk_i(CLKX4), .rst_i(RESET), .async_i(bus.SCLK),
    .sync_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_ncs_sync (
    .clk_i(CLKX4), .rst_i(RESET), .async_i(bus.nCS),
    .sync_o(ncs_sync), .rise_o(ncs_rise_unused), .fall_o(ncs_fall)
  );

  framer_state_e state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [6:0]  crc_q, crc_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic [31:0] cmd_arg_q, cmd_arg_d;
  logic        cmd_crc_ok_q, cmd_crc_ok_d;
  logic [7:0]  tx_sr_q, tx_sr_d;
  logic        miso_q, miso_d;
  logic [3:0]  ncr_q, ncr_d;

  logic [7:0]  rx_byte;
  logic [6:0]  crc_upd;
  logic        byte_done, cmd_done, tx_take;

  always_ff @(posedge CLKX4) begin
    if (RESET) begin
      mosi_meta_q  <= 1'b1;
      mosi_sync_q  <= 1'b1;
      state_q      <= IDLE;
      k_q          <= '0;
      idx_q        <= '0;
      arg_q        <= '0;
      crc_q        <= '0;
      bit_cnt_q    <= '0;
      rx_sr_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_index_q  <= '0;
      cmd_arg_q    <= '0;
      cmd_crc_ok_q <= 1'b0;
      tx_sr_q      <= FILL_BYTE;
      miso_q       <= 1'b1;
      ncr_q        <= '0;
    end else begin
      mosi_meta_q  <= bus.MOSI;
      mosi_sync_q  <= mosi_meta_q;
      state_q      <= state_d;
      k_q          <= k_d;
      idx_q        <= idx_d;
      arg_q        <= arg_d;
      crc_q        <= crc_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_sr_q      <= rx_sr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_index_q  <= cmd_index_d;
      cmd_arg_q    <= cmd_arg_d;
      cmd_crc_ok_q <= cmd_crc_ok_d;
      tx_sr_q      <= tx_sr_d;
      miso_q       <= miso_d;
      ncr_q        <= ncr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    idx_d        = idx_q;
    arg_d        = arg_q;
    crc_d        = crc_q;
    bit_cnt_d    = bit_cnt_q;
    rx_sr_d      = rx_sr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    cmd_valid_d  = 1'b0;
    cmd_index_d  = cmd_index_q;
    cmd_arg_d    = cmd_arg_q;
    cmd_crc_ok_d = cmd_crc_ok_q;
    tx_sr_d      = tx_sr_q;
    miso_d       = miso_q;
    ncr_d        = ncr_q;
    cmd_done     = 1'b0;
    tx_take      = 1'b0;

    rx_byte   = {rx_sr_q[6:0], mosi_sync_q};
    byte_done = sclk_rise && !ncs_sync && (bit_cnt_q == 3'd7);

    // CRC runs over bytes 0-4; a new frame starts from zero.
    crc_upd = (state_q == IDLE) ? 7'h00 : crc_q;
    for (int i = 7; i >= 0; i--) begin
      crc_upd = crc7_next(crc_upd, rx_byte[i]);
    end

    if (sclk_rise && !ncs_sync) begin
      rx_sr_d   = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    if (sclk_fall && !ncs_sync) begin
      miso_d  = tx_sr_q[7];
      tx_sr_d = {tx_sr_q[6:0], 1'b1};
    end

    if (byte_done) begin
      rx_data_d  = rx_byte;
      rx_valid_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (rx_byte[7:6] == CMD_START_BITS) begin
            state_d = ARG;
            k_d     = 2'd0;
            idx_d   = rx_byte[5:0];
            crc_d   = crc_upd;
          end
        end
        ARG: begin
          arg_d = {arg_q[23:0], rx_byte};
          crc_d = crc_upd;
          k_d   = k_q + 2'd1;
          if (k_q == 2'd3) state_d = CRC;
        end
        CRC: begin
          cmd_valid_d  = 1'b1;
          cmd_index_d  = idx_q;
          cmd_arg_d    = arg_q;
          cmd_crc_ok_d = (rx_byte[7:1] == crc_q) && rx_byte[0];
          cmd_done     = 1'b1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // The NCR load and its first decrement share this boundary, so the
      // byte right after the CRC byte is already a fill byte.
      if (cmd_done) begin
        tx_sr_d = FILL_BYTE;
        ncr_d   = NCR_LOAD - 4'd1;
      end else if (ncr_q != 4'd0) begin
        tx_sr_d = FILL_BYTE;
        ncr_d   = ncr_q - 4'd1;
      end else if (bus.TX_VALID) begin
        tx_sr_d = bus.TX_DATA;
        tx_take = 1'b1;
      end else begin
        tx_sr_d = FILL_BYTE;
      end
    end

    if (ncs_fall) begin
      tx_sr_d = FILL_BYTE;
      miso_d  = 1'b1;
    end

    // Deselected: drop any partial byte/frame and pending NCR fill.
    if (ncs_sync) begin
      bit_cnt_d = 3'd0;
      state_d   = IDLE;
      ncr_d     = 4'd0;
      miso_d    = 1'b1;
    end
  end

  assign bus.MISO       = miso_q | ncs_sync;
  assign bus.RX_DATA    = rx_data_q;
  assign bus.RX_VALID   = rx_valid_q;
  assign bus.CMD_VALID  = cmd_valid_q;
  assign bus.CMD_INDEX  = cmd_index_q;
  assign bus.CMD_ARG    = cmd_arg_q;
  assign bus.CMD_CRC_OK = cmd_crc_ok_q;
  assign bus.TX_READY   = tx_take & ~RESET;
endmodule
